ereg_rr_arbiter: RTL

Round-robin write arbiter that shares one W-bit enabled register bank between N requesters. The bank is built from the team's enable-mux/DFF cells and each bit has ports Ce, Din, Qout. The arbiter picks one requester, drives the bank's Ce for exactly one cycle with the winner's data on Din, then completes a four-phase req/ack handshake with that requester. It sits between the requester blocks and the shared register bank.

---
 rtl/ereg_rr_arbiter_if.sv | 16 +
 rtl/ereg_rr_arbiter.sv | 56 +++++
 2 files changed

// File: rtl/ereg_rr_arbiter_if.sv
// ereg_rr_arbiter_if: requester and shared-bank signals of the arbiter (req/din/ack on the requester side; Ce/Din to the bank; grant_id and busy as status)
interface ereg_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int GW = $clog2(N);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   ack;
  logic           Ce;
  logic [W-1:0]   Din;
  logic [GW-1:0]  grant_id;
  logic           busy;
  modport master (output req, din, input ack, Ce, Din, grant_id, busy);
  modport slave  (input req, din, output ack, Ce, Din, grant_id, busy);
endinterface

// File: rtl/ereg_rr_arbiter.sv
// ereg_rr_arbiter: round-robin write arbiter; ports CLK, RST (async active-low), bus (slave: req/din in, ack/Ce/Din/grant_id/busy out, all registered)
module ereg_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic CLK,
  input logic RST,
  ereg_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2;
  logic [1:0]    state;
  logic [GW-1:0] ptr, g, idx;
  // scan downward from ptr+N-1 to ptr so the last hit is the first set bit at or after ptr
  always_comb begin
    g = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % N);
      if (bus.req[idx]) g = idx;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      ptr <= '0;
      bus.Ce <= 1'b0;
      bus.ack <= '0;
      bus.Din <= '0;
      bus.grant_id <= '0;
      bus.busy <= 1'b0;
    end else
      case (state)
        IDLE:
          if (|bus.req) begin
            state <= WRITE;
            bus.Din <= bus.din[g*W +: W];
            bus.grant_id <= g;
            bus.Ce <= 1'b1;
            bus.busy <= 1'b1;
          end
        WRITE: begin
          state <= ACK;
          bus.Ce <= 1'b0;
          bus.ack <= N'(1) << bus.grant_id;
        end
        ACK:
          if (!bus.req[bus.grant_id]) begin
            state <= IDLE;
            bus.ack <= '0;
            bus.busy <= 1'b0;
            ptr <= (bus.grant_id == GW'(N - 1)) ? '0 : bus.grant_id + 1'b1;
          end
        default: state <= IDLE;
      endcase
endmodule
